// File: rtl/padctl_strap.sv
// padctl_strap: pad-control block sitting between the chip pads and the core.
//
// Purpose
//   - Synchronises the strap pins, waits for them to be stable for
//     StrapSettleCycles consecutive cycles, latches them and re-samples on
//     request.
//   - Synchronises every GPIO input and optionally glitch-filters it.
//   - Passes GPIO output value/enable straight through to the pads.
//   - Steers the shared debug pads to the JTAG TAP or the SPI device,
//     according to strap bit 0, once the straps are latched.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   strap_pad_i             raw strap pads
//   strap_resample_i        single-cycle request to re-sample the straps
//   strap_o, strap_valid_o  latched straps and their valid flag
//   gpio_pad_i              raw GPIO pad inputs
//   gpio_filter_en_i        per-pin glitch filter enable (quasi-static)
//   gpio_p2d_o              synchronised / filtered GPIO inputs to the core
//   gpio_d2p_i, gpio_en_d2p_i   core output value / enable
//   gpio_pad_o, gpio_pad_oe_o   pad output value / enable (pass-through)
//   dps_pad_i               debug pads: [0] tck/sck [1] tdi/mosi [2] tms/csb [3] trst_n
//   dps_pad_o, dps_pad_oe_o tdo/miso pad value and enable
//   jtag_*                  TAP side of the debug mux
//   spi_*                   SPI device side of the debug mux

module padctl_strap #(
  parameter int unsigned NumGpio           = 32,
  parameter int unsigned NumStraps         = 2,
  parameter int unsigned StrapSettleCycles = 16,
  parameter int unsigned FilterCycles      = 4,
  parameter int unsigned SyncStages        = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,

  input  logic [NumStraps-1:0] strap_pad_i,
  input  logic                 strap_resample_i,
  output logic [NumStraps-1:0] strap_o,
  output logic                 strap_valid_o,

  input  logic [NumGpio-1:0]   gpio_pad_i,
  input  logic [NumGpio-1:0]   gpio_filter_en_i,
  output logic [NumGpio-1:0]   gpio_p2d_o,
  input  logic [NumGpio-1:0]   gpio_d2p_i,
  input  logic [NumGpio-1:0]   gpio_en_d2p_i,
  output logic [NumGpio-1:0]   gpio_pad_o,
  output logic [NumGpio-1:0]   gpio_pad_oe_o,

  input  logic [3:0]           dps_pad_i,
  output logic                 dps_pad_o,
  output logic                 dps_pad_oe_o,

  output logic                 jtag_tck_o,
  output logic                 jtag_tms_o,
  output logic                 jtag_tdi_o,
  output logic                 jtag_trst_n_o,
  input  logic                 jtag_tdo_i,

  output logic                 spi_sck_o,
  output logic                 spi_csb_o,
  output logic                 spi_mosi_o,
  input  logic                 spi_miso_i,
  input  logic                 spi_miso_en_i
);

  localparam int unsigned CntW  = (StrapSettleCycles > 1) ? $clog2(StrapSettleCycles) : 1;
  localparam int unsigned FcntW = (FilterCycles > 1) ? $clog2(FilterCycles) : 1;

  localparam logic [CntW-1:0]  CntLast  = CntW'(StrapSettleCycles - 1);
  localparam logic [FcntW-1:0] FcntLast = FcntW'(FilterCycles - 1);

  typedef enum logic {
    ST_SETTLE  = 1'b0,
    ST_LATCHED = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Strap path
  // ---------------------------------------------------------------------------

  logic [SyncStages-1:0][NumStraps-1:0] strap_sync_q;
  logic [NumStraps-1:0]                 strap_sync;

  // Strap synchroniser; stage 0 faces the pad.
  always_ff @(posedge clk_i or posedge rst_i) begin : strap_sync_ff
    if (rst_i) begin
      strap_sync_q <= '0;
    end else begin
      strap_sync_q <= {strap_sync_q[SyncStages-2:0], strap_pad_i};
    end
  end

  assign strap_sync = strap_sync_q[SyncStages-1];

  state_e               state_q, state_d;
  logic [NumStraps-1:0] cand_q;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [NumStraps-1:0] strap_q, strap_d;
  logic                 valid_q, valid_d;

  // Strap FSM state and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin : strap_fsm_ff
    if (rst_i) begin
      state_q <= ST_SETTLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      strap_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // The candidate always follows the synchroniser, so a change is seen as
      // a one-cycle mismatch between the two.
      cand_q  <= strap_sync;
      cnt_q   <= cnt_d;
      strap_q <= strap_d;
      valid_q <= valid_d;
    end
  end

  // Strap FSM next-state logic.
  always_comb begin : strap_fsm_comb
    state_d = state_q;
    cnt_d   = cnt_q;
    strap_d = strap_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_SETTLE: begin
        if (strap_sync != cand_q) begin
          cnt_d = '0;
        end else if (cnt_q == CntLast) begin
          strap_d = cand_q;
          valid_d = 1'b1;
          state_d = ST_LATCHED;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      ST_LATCHED: begin
        // strap_q keeps the old value until the next latch.
        if (strap_resample_i) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_SETTLE;
      end
    endcase
  end

  assign strap_o       = strap_q;
  assign strap_valid_o = valid_q;

  // ---------------------------------------------------------------------------
  // Debug pad mux: combinational from registered strap state, so an
  // asynchronous reset idles both interfaces in the same cycle.
  // ---------------------------------------------------------------------------

  always_comb begin : dbg_mux
    jtag_tck_o    = 1'b0;
    jtag_tms_o    = 1'b1;
    jtag_tdi_o    = 1'b0;
    jtag_trst_n_o = 1'b0;
    spi_sck_o     = 1'b0;
    spi_csb_o     = 1'b1;
    spi_mosi_o    = 1'b0;
    dps_pad_o     = 1'b0;
    dps_pad_oe_o  = 1'b0;

    if (valid_q) begin
      if (!strap_q[0]) begin
        jtag_tck_o    = dps_pad_i[0];
        jtag_tdi_o    = dps_pad_i[1];
        jtag_tms_o    = dps_pad_i[2];
        jtag_trst_n_o = dps_pad_i[3];
        dps_pad_o     = jtag_tdo_i;
        dps_pad_oe_o  = 1'b1;
      end else begin
        spi_sck_o     = dps_pad_i[0];
        spi_mosi_o    = dps_pad_i[1];
        spi_csb_o     = dps_pad_i[2];
        dps_pad_o     = spi_miso_i;
        dps_pad_oe_o  = spi_miso_en_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // GPIO input path
  // ---------------------------------------------------------------------------

  logic [SyncStages-1:0][NumGpio-1:0] gpio_sync_q;
  logic [NumGpio-1:0]                 gpio_sync;
  logic [NumGpio-1:0]                 gpio_filt;

  // GPIO input synchroniser; stage 0 faces the pad.
  always_ff @(posedge clk_i or posedge rst_i) begin : gpio_sync_ff
    if (rst_i) begin
      gpio_sync_q <= '0;
    end else begin
      gpio_sync_q <= {gpio_sync_q[SyncStages-2:0], gpio_pad_i};
    end
  end

  assign gpio_sync = gpio_sync_q[SyncStages-1];

  for (genvar g = 0; g < int'(NumGpio); g++) begin : g_filt
    logic             filt_q;
    logic [FcntW-1:0] fcnt_q;

    // Glitch filter: the output follows the input only after FilterCycles
    // consecutive mismatching cycles; fcnt tops out at FilterCycles-1.
    always_ff @(posedge clk_i or posedge rst_i) begin : filt_ff
      if (rst_i) begin
        filt_q <= 1'b0;
        fcnt_q <= '0;
      end else if (gpio_sync[g] == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FcntLast) begin
        filt_q <= gpio_sync[g];
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + FcntW'(1);
      end
    end

    assign gpio_filt[g] = filt_q;
  end

  assign gpio_p2d_o = (gpio_filter_en_i & gpio_filt) | (~gpio_filter_en_i & gpio_sync);

  // ---------------------------------------------------------------------------
  // GPIO output path: straight pass-through.
  // ---------------------------------------------------------------------------

  assign gpio_pad_o    = gpio_d2p_i;
  assign gpio_pad_oe_o = gpio_en_d2p_i;

endmodule

// File: tb/tb_padctl_strap.sv
// Self-checking bench for padctl_strap with default parameters.
// Expected values come from a history-based reference: every pad value and
// resample request applied at each clock edge is recorded, and the expected
// outputs are recomputed from that history using the strap / filter rules.

module tb_padctl_strap;

  localparam int NG   = 32;
  localparam int NS   = 2;
  localparam int SET  = 16;
  localparam int FC   = 4;
  localparam int SS   = 2;
  localparam int MAXE = 1024;

  logic          clk;
  logic          rst;
  logic [NS-1:0] strap_pad;
  logic          strap_resample;
  logic [NS-1:0] strap_o;
  logic          strap_valid_o;
  logic [NG-1:0] gpio_pad;
  logic [NG-1:0] gpio_filter_en;
  logic [NG-1:0] gpio_p2d_o;
  logic [NG-1:0] gpio_d2p;
  logic [NG-1:0] gpio_en_d2p;
  logic [NG-1:0] gpio_pad_o;
  logic [NG-1:0] gpio_pad_oe_o;
  logic [3:0]    dps_pad;
  logic          dps_pad_o;
  logic          dps_pad_oe_o;
  logic          jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_n_o;
  logic          jtag_tdo;
  logic          spi_sck_o, spi_csb_o, spi_mosi_o;
  logic          spi_miso, spi_miso_en;

  int total = 0;
  int bad   = 0;
  int e     = 0;   // clock edges since the last reset release

  logic [NS-1:0] pad_hist [MAXE];
  logic          res_hist [MAXE];
  logic [NG-1:0] gp_hist  [MAXE];

  localparam logic [8:0] DBG_IDLE = 9'b010_001_0_0_0;

  padctl_strap #(
    .NumGpio(NG), .NumStraps(NS), .StrapSettleCycles(SET),
    .FilterCycles(FC), .SyncStages(SS)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .strap_pad_i(strap_pad), .strap_resample_i(strap_resample),
    .strap_o(strap_o), .strap_valid_o(strap_valid_o),
    .gpio_pad_i(gpio_pad), .gpio_filter_en_i(gpio_filter_en),
    .gpio_p2d_o(gpio_p2d_o),
    .gpio_d2p_i(gpio_d2p), .gpio_en_d2p_i(gpio_en_d2p),
    .gpio_pad_o(gpio_pad_o), .gpio_pad_oe_o(gpio_pad_oe_o),
    .dps_pad_i(dps_pad), .dps_pad_o(dps_pad_o), .dps_pad_oe_o(dps_pad_oe_o),
    .jtag_tck_o(jtag_tck_o), .jtag_tms_o(jtag_tms_o), .jtag_tdi_o(jtag_tdi_o),
    .jtag_trst_n_o(jtag_trst_n_o), .jtag_tdo_i(jtag_tdo),
    .spi_sck_o(spi_sck_o), .spi_csb_o(spi_csb_o), .spi_mosi_o(spi_mosi_o),
    .spi_miso_i(spi_miso), .spi_miso_en_i(spi_miso_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strap value seen by the settle comparison at edge k (pad sampled SS edges earlier).
  function automatic logic [NS-1:0] cmpv(input int k);
    return (k > SS) ? pad_hist[k-SS] : '0;
  endfunction

  // Valid/strap after edge 'upto': latch once the compared value has been
  // unchanged for SET edges since the last restart (reset, change, resample).
  task automatic model_strap(input int upto, output logic v, output logic [NS-1:0] s);
    int r;
    r = 0; v = 1'b0; s = '0;
    for (int k = 1; k <= upto; k++) begin
      if (!v) begin
        if (cmpv(k) != cmpv(k-1)) r = k;
        else if (k - r == SET) begin v = 1'b1; s = cmpv(k); end
      end else if (res_hist[k]) begin
        v = 1'b0; r = k;
      end
    end
  endtask

  // Synchronised GPIO value visible after edge k.
  function automatic logic [NG-1:0] syncv(input int k);
    return (k >= SS) ? gp_hist[k-SS+1] : '0;
  endfunction

  function automatic logic [NG-1:0] model_gpio(input int upto, input logic [NG-1:0] en);
    logic [NG-1:0] res, sv, now;
    logic f;
    int run;
    now = syncv(upto);
    for (int p = 0; p < NG; p++) begin
      f = 1'b0; run = 0;
      for (int k = 1; k <= upto; k++) begin
        sv = syncv(k-1);
        if (sv[p] != f) begin
          run++;
          if (run == FC) begin f = sv[p]; run = 0; end
        end else run = 0;
      end
      res[p] = en[p] ? f : now[p];
    end
    return res;
  endfunction

  function automatic logic [8:0] dbg_exp(input logic v, input logic [NS-1:0] s);
    logic [8:0] d;
    d = DBG_IDLE;
    if (v && !s[0])
      d = {dps_pad[0], dps_pad[2], dps_pad[1], dps_pad[3], 1'b0, 1'b1, 1'b0, jtag_tdo, 1'b1};
    else if (v && s[0])
      d = {1'b0, 1'b1, 1'b0, 1'b0, dps_pad[0], dps_pad[2], dps_pad[1], spi_miso, spi_miso_en};
    return d;
  endfunction

  function automatic logic [8:0] dbg_obs();
    return {jtag_tck_o, jtag_tms_o, jtag_tdi_o, jtag_trst_n_o,
            spi_sck_o, spi_csb_o, spi_mosi_o, dps_pad_o, dps_pad_oe_o};
  endfunction

  task automatic check_all();
    logic v;
    logic [NS-1:0] s;
    model_strap(e, v, s);
    chk("strap_valid", 64'(strap_valid_o), 64'(v));
    chk("strap", 64'(strap_o), 64'(s));
    chk("gpio_p2d", 64'(gpio_p2d_o), 64'(model_gpio(e, gpio_filter_en)));
    chk("dbg", 64'(dbg_obs()), 64'(dbg_exp(v, s)));
    chk("gpio_out", {gpio_pad_o, gpio_pad_oe_o}, {gpio_d2p, gpio_en_d2p});
  endtask

  task automatic step();
    pad_hist[e+1] = strap_pad;
    res_hist[e+1] = strap_resample;
    gp_hist[e+1]  = gpio_pad;
    @(posedge clk);
    e++;
    @(negedge clk);
    check_all();
  endtask

  task automatic run_to(input int n);
    while (e < n) step();
  endtask

  // Asserts reset, checks the asynchronous reset values, releases on a negedge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", 64'(strap_valid_o), 64'(0));
    chk("rst_strap", 64'(strap_o), 64'(0));
    chk("rst_p2d", 64'(gpio_p2d_o), 64'(0));
    chk("rst_dbg", 64'(dbg_obs()), 64'(DBG_IDLE));
    @(negedge clk);
    rst = 1'b0;
    e = 0;
    for (int k = 0; k < MAXE; k++) begin
      pad_hist[k] = '0; res_hist[k] = 1'b0; gp_hist[k] = '0;
    end
  endtask

  initial begin
    int r0;
    strap_pad = 2'b01; strap_resample = 1'b0;
    gpio_pad = '0; gpio_filter_en = '0; gpio_d2p = 32'hA5A5_0F0F; gpio_en_d2p = 32'h1234_5678;
    dps_pad = 4'h0; jtag_tdo = 1'b0; spi_miso = 1'b0; spi_miso_en = 1'b0;

    // Straps 01 held through reset: latch after edge SET+SS+1.
    do_reset();
    run_to(18);
    chk("t1_valid_e18", 64'(strap_valid_o), 64'(0));
    step();
    chk("t1_valid_e19", 64'(strap_valid_o), 64'(1));
    chk("t1_strap", 64'(strap_o), 64'(2'b01));
    dps_pad = 4'b0001;
    step();
    chk("t1_sck_hi", 64'(spi_sck_o), 64'(1));
    chk("t1_tms_idle", 64'(jtag_tms_o), 64'(1));
    dps_pad = 4'b0000;
    step();
    chk("t1_sck_lo", 64'(spi_sck_o), 64'(0));

    // Zero straps with a one-cycle glitch on bit 1 sampled at edge 10.
    strap_pad = 2'b00;
    do_reset();
    run_to(9);
    strap_pad = 2'b10;
    step();
    strap_pad = 2'b00;
    run_to(28);
    chk("t2_valid_e28", 64'(strap_valid_o), 64'(0));
    step();
    chk("t2_valid_e29", 64'(strap_valid_o), 64'(1));
    chk("t2_strap", 64'(strap_o), 64'(2'b00));
    chk("t2_oe", 64'(dps_pad_oe_o), 64'(1));
    jtag_tdo = 1'b1;
    step();
    chk("t2_tdo", 64'(dps_pad_o), 64'(1));

    // Strap change while latched is ignored; resample relatches into SPI mode.
    strap_pad = 2'b01;
    repeat (4) step();
    chk("t3_hold_strap", 64'(strap_o), 64'(2'b00));
    chk("t3_hold_valid", 64'(strap_valid_o), 64'(1));
    dps_pad = 4'hF; spi_miso = 1'b1; spi_miso_en = 1'b1;
    strap_resample = 1'b1;
    step();
    strap_resample = 1'b0;
    r0 = e;
    chk("t3_drop", 64'(strap_valid_o), 64'(0));
    chk("t3_idle", 64'(dbg_obs()), 64'(DBG_IDLE));
    run_to(r0 + 15);
    chk("t3_still_low", 64'(strap_valid_o), 64'(0));
    dps_pad = 4'b1011;
    step();
    chk("t3_relatch", 64'(strap_valid_o), 64'(1));
    chk("t3_strap", 64'(strap_o), 64'(2'b01));
    chk("t3_csb", 64'(spi_csb_o), 64'(0));
    chk("t3_miso_oe", 64'(dps_pad_oe_o), 64'(1));

    // GPIO pin 3: short filtered pulse, sustained filtered, unfiltered.
    strap_pad = 2'b00;
    gpio_filter_en = 32'h0000_0008;
    gpio_pad = 32'h0000_0008;
    do_reset();
    repeat (3) step();
    gpio_pad = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t4_pulse_blocked", 64'(gpio_p2d_o[3]), 64'(0));
    end
    gpio_pad = 32'h0000_0008;
    do_reset();
    run_to(5);
    chk("t4_filt_e5", 64'(gpio_p2d_o[3]), 64'(0));
    step();
    chk("t4_filt_e6", 64'(gpio_p2d_o[3]), 64'(1));
    gpio_filter_en = '0;
    do_reset();
    step();
    chk("t4_raw_e1", 64'(gpio_p2d_o[3]), 64'(0));
    step();
    chk("t4_raw_e2", 64'(gpio_p2d_o[3]), 64'(1));

    // Reset mid-settle and mid-filter count, then full restart.
    gpio_pad = '1;
    gpio_filter_en = 32'hFFFF_0000;
    do_reset();
    run_to(4);
    chk("t5_pre_p2d", 64'(gpio_p2d_o), 64'(32'h0000_FFFF));
    do_reset();
    run_to(5);
    chk("t5_p2d_e5", 64'(gpio_p2d_o), 64'(32'h0000_FFFF));
    step();
    chk("t5_p2d_e6", 64'(gpio_p2d_o), 64'(32'hFFFF_FFFF));
    run_to(15);
    chk("t5_valid_e15", 64'(strap_valid_o), 64'(0));
    step();
    chk("t5_valid_e16", 64'(strap_valid_o), 64'(1));

    // Randomised traffic checked every cycle against the reference.
    gpio_filter_en = $urandom;
    gpio_pad = $urandom;
    strap_pad = 2'($urandom_range(0, 3));
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) strap_pad = 2'($urandom_range(0, 3));
      strap_resample = ($urandom_range(0, 14) == 0);
      gpio_pad    = gpio_pad ^ ($urandom & $urandom & $urandom);
      gpio_d2p    = $urandom;
      gpio_en_d2p = $urandom;
      dps_pad     = 4'($urandom_range(0, 15));
      jtag_tdo    = 1'($urandom_range(0, 1));
      spi_miso    = 1'($urandom_range(0, 1));
      spi_miso_en = 1'($urandom_range(0, 1));
      step();
    end
    strap_resample = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
